// File: rtl/first_nios2_system_cpu_div_cell.sv
// Iterative radix-2 restoring divider for the Nios II M-stage: 32 quotient bits,
// one per cycle, followed by a sign-fix cycle and a one-cycle done pulse.
module first_nios2_system_cpu_div_cell (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] M_div_src1,
  input  logic [31:0] M_div_src2,
  input  logic        M_div_signed,
  input  logic        M_div_start,
  input  logic        M_div_kill,
  output logic        M_div_busy,
  output logic        M_div_done,
  output logic [31:0] M_div_quotient,
  output logic [31:0] M_div_remainder
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [32:0] rem_q;
  logic [31:0] quo_q, dvs_q, src1_q;
  logic        neg_a_q, neg_b_q, div0_q, ovf_q;
  logic [31:0] q_out_q, r_out_q;

  logic        accept;
  logic        neg_a, neg_b;
  logic [32:0] shifted;
  logic [33:0] trial;
  logic [31:0] q_fix, r_fix;

  assign accept  = (state_q == IDLE) && M_div_start && !M_div_kill;
  assign neg_a   = M_div_signed && M_div_src1[31];
  assign neg_b   = M_div_signed && M_div_src2[31];
  // The 34-bit trial keeps the borrow visible even when the shifted remainder uses bit 32.
  assign shifted = {rem_q[31:0], quo_q[31]};
  assign trial   = {1'b0, shifted} - {2'b00, dvs_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (M_div_kill) state_d = IDLE;
               else if (cnt_q == 6'd31) state_d = FIX;
      FIX:     state_d = M_div_kill ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    M_div_busy = (state_q == CALC) || (state_q == FIX);
    M_div_done = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      src1_q  <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= neg_a ? -M_div_src1 : M_div_src1;
      dvs_q   <= neg_b ? -M_div_src2 : M_div_src2;
      src1_q  <= M_div_src1;
      neg_a_q <= neg_a;
      neg_b_q <= neg_b;
      div0_q  <= (M_div_src2 == 32'h0);
      ovf_q   <= M_div_signed && (M_div_src1 == 32'h8000_0000) &&
                 (M_div_src2 == 32'hFFFF_FFFF);
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q + 6'd1;
      if (!trial[33]) begin
        rem_q <= trial[32:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= shifted;
        quo_q <= {quo_q[30:0], 1'b0};
      end
    end
  end

  always_comb begin
    q_fix = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
    r_fix = neg_a_q ? -rem_q[31:0] : rem_q[31:0];
    if (div0_q) begin
      q_fix = 32'hFFFF_FFFF;
      r_fix = src1_q;
    end else if (ovf_q) begin
      q_fix = 32'h8000_0000;
      r_fix = 32'h0;
    end
  end

  // Results only land on a FIX cycle that is not flushed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_out_q <= '0;
      r_out_q <= '0;
    end else if (state_q == FIX && !M_div_kill) begin
      q_out_q <= q_fix;
      r_out_q <= r_fix;
    end
  end

  assign M_div_quotient  = q_out_q;
  assign M_div_remainder = r_out_q;

endmodule
